des_key_sched_ctrl: RTL and testbench

Sequences the DES key schedule. It accepts the 56-bit PC-1-permuted key and its error flag from the key-check stage. It then delivers the 16 rotated C/D round states, one per valid/ready handshake, to the round engine (PC-2 is applied downstream). Encrypt or decrypt rotation order is selected per key. The block also handles key errors, aborts and completion signalling.

---
 rtl/des_key_sched_ctrl.sv | 116 +++++++++++
 tb/tb_des_key_sched_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_ctrl.sv
// DES key schedule sequencer: rotates the PC-1 C/D halves and offers one round state per handshake.
// Round 0 is valid the cycle after key acceptance; the current round holds while ready is low.
module des_key_sched_ctrl (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [55:0] sub_key_in,
    input  logic        sub_key_in_valid,
    input  logic        sub_key_err_in,
    input  logic        decrypt_in,
    input  logic        abort_in,
    input  logic        round_key_ready_in,
    output logic [55:0] round_key_out,
    output logic [3:0]  round_idx_out,
    output logic        round_key_valid_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  idx_q, idx_d;
    logic        dir_q, dir_d;
    logic        err_q, err_d;

    // Decrypt starts from the unrotated key, so its first shift is zero.
    function automatic logic [1:0] shift_amt(input logic [3:0] i, input logic dec);
        logic [1:0] amt;
        if (dec && (i == 4'd0))
            amt = 2'd0;
        else if ((i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15))
            amt = 2'd1;
        else
            amt = 2'd2;
        return amt;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n, input logic dec);
        logic [27:0] r;
        case (n)
            2'd1:    r = dec ? {x[0], x[27:1]}   : {x[26:0], x[27]};
            2'd2:    r = dec ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n, input logic dec);
        return {rot28(cd[55:28], n, dec), rot28(cd[27:0], n, dec)};
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sub_key_err_in) begin
                    err_d = 1'b1;
                end else if (sub_key_in_valid) begin
                    dir_d   = decrypt_in;
                    cd_d    = rot_cd(sub_key_in, shift_amt(4'd0, decrypt_in), decrypt_in);
                    idx_d   = 4'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // Abort wins over a same-cycle handshake; that round is not consumed.
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (round_key_ready_in) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cd_d  = rot_cd(cd_q, shift_amt(idx_q + 4'd1, dir_q), dir_q);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign round_key_out       = cd_q;
    assign round_idx_out       = idx_q;
    assign round_key_valid_out = (state_q == ST_ROUND);
    assign busy_out            = (state_q == ST_ROUND);
    assign done_out            = (state_q == ST_DONE);
    assign err_out             = err_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: directed and random key schedules checked against a cumulative-shift model.
module tb_des_key_sched_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [55:0] sub_key_in = '0;
    logic        sub_key_in_valid = 1'b0;
    logic        sub_key_err_in = 1'b0;
    logic        decrypt_in = 1'b0;
    logic        abort_in = 1'b0;
    logic        round_key_ready_in = 1'b0;
    logic [55:0] round_key_out;
    logic [3:0]  round_idx_out;
    logic        round_key_valid_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    des_key_sched_ctrl dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .sub_key_in         (sub_key_in),
        .sub_key_in_valid   (sub_key_in_valid),
        .sub_key_err_in     (sub_key_err_in),
        .decrypt_in         (decrypt_in),
        .abort_in           (abort_in),
        .round_key_ready_in (round_key_ready_in),
        .round_key_out      (round_key_out),
        .round_idx_out      (round_idx_out),
        .round_key_valid_out(round_key_valid_out),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .err_out            (err_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [55:0] exp_keys [16];
    logic [55:0] obs_keys [16];

    // Standard DES left-shift table, and its decrypt counterpart (right shifts, first round unshifted).
    int enc_sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_sh [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int k);
        logic [55:0] w;
        w = {x, x};
        w = w >> (28 - k);
        return w[27:0];
    endfunction

    // Round i key = original halves rotated by the running total of shifts up to i.
    task automatic build(input logic [55:0] key, input logic dec);
        int cum;
        int k;
        cum = 0;
        for (int i = 0; i < 16; i++) begin
            cum += dec ? dec_sh[i] : enc_sh[i];
            k = dec ? (28 - (cum % 28)) % 28 : cum % 28;
            exp_keys[i] = {rotl28(key[55:28], k), rotl28(key[27:0], k)};
        end
    endtask

    function automatic logic [55:0] rand56();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[55:0];
    endfunction

    // Called and returns at a negedge. mode: 0 ready high, 1 pattern 1,0,0,1, 2 random ready.
    task automatic run(input string tag, input logic [55:0] key, input logic dec,
                       input int mode, input int inject_hs);
        int hs;
        int cyc;
        build(key, dec);
        sub_key_in = key; decrypt_in = dec; sub_key_in_valid = 1'b1;
        round_key_ready_in = 1'b0;
        @(negedge clk_in);
        sub_key_in_valid = 1'b0;
        hs = 0;
        cyc = 1;
        while (hs < 16 && cyc < 200) begin
            case (mode)
                0:       round_key_ready_in = 1'b1;
                1:       round_key_ready_in = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: round_key_ready_in = 1'($urandom_range(0, 1));
            endcase
            decrypt_in       = 1'($urandom_range(0, 1));
            sub_key_in       = rand56();
            sub_key_in_valid = (inject_hs == hs);
            sub_key_err_in   = (inject_hs == hs);
            obs_keys[hs] = round_key_out;
            chk({tag, "_round"},
                {done_out, busy_out, err_out, round_key_valid_out, round_idx_out, round_key_out},
                {1'b0, 1'b1, 1'b0, 1'b1, 4'(hs), exp_keys[hs]});
            if (round_key_ready_in) hs++;
            @(negedge clk_in);
            cyc++;
        end
        sub_key_in_valid = 1'b0;
        sub_key_err_in   = 1'b0;
        round_key_ready_in = 1'b0;
        chk({tag, "_handshakes"}, 64'(hs), 64'd16);
        chk({tag, "_done"}, {61'd0, done_out, busy_out, round_key_valid_out}, {61'd0, 3'b100});
        if (mode == 0) chk({tag, "_done_latency"}, 64'(cyc), 64'd17);
        // A key offered in the DONE cycle must be dropped.
        sub_key_in = key; sub_key_in_valid = 1'b1;
        @(negedge clk_in);
        sub_key_in_valid = 1'b0;
        chk({tag, "_idle_after"}, {60'd0, done_out, busy_out, round_key_valid_out, err_out}, 64'd0);
    endtask

    initial begin
        logic [55:0] k2;
        @(negedge clk_in);
        chk("reset_outputs",
            {round_key_out, round_idx_out, 1'b0, round_key_valid_out, busy_out, done_out, err_out}, 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        run("enc", 56'h0000001_0000001, 1'b0, 0, -1);
        chk("enc_r0",  {8'd0, obs_keys[0]},  {8'd0, 56'h0000002_0000002});
        chk("enc_r1",  {8'd0, obs_keys[1]},  {8'd0, 56'h0000004_0000004});
        chk("enc_r2",  {8'd0, obs_keys[2]},  {8'd0, 56'h0000010_0000010});
        chk("enc_r15", {8'd0, obs_keys[15]}, {8'd0, 56'h0000001_0000001});

        run("dec", 56'h0000001_0000001, 1'b1, 0, -1);
        chk("dec_r0", {8'd0, obs_keys[0]}, {8'd0, 56'h0000001_0000001});
        chk("dec_r1", {8'd0, obs_keys[1]}, {8'd0, 56'h8000000_8000000});
        chk("dec_r2", {8'd0, obs_keys[2]}, {8'd0, 56'h2000000_2000000});

        run("bp", 56'h0000001_0000001, 1'b0, 1, -1);
        chk("bp_r15", {8'd0, obs_keys[15]}, {8'd0, 56'h0000001_0000001});
        run("bp_dec", rand56(), 1'b1, 1, -1);

        for (int r = 0; r < 6; r++)
            run("rand", rand56(), 1'($urandom_range(0, 1)), 2, -1);

        run("inject", rand56(), 1'b0, 0, 3);
        run("inject_bp", rand56(), 1'b1, 2, 7);

        // Key error beats a simultaneous valid.
        sub_key_in = rand56(); sub_key_in_valid = 1'b1; sub_key_err_in = 1'b1;
        @(negedge clk_in);
        sub_key_in_valid = 1'b0; sub_key_err_in = 1'b0;
        chk("err_pulse", {61'd0, err_out, busy_out, round_key_valid_out}, {61'd0, 3'b100});
        @(negedge clk_in);
        chk("err_clear", {61'd0, err_out, busy_out, round_key_valid_out}, 64'd0);

        // Abort at idx 5 with ready high, then a fresh key the following cycle.
        build(56'h0123456_789ABCD, 1'b0);
        sub_key_in = 56'h0123456_789ABCD; decrypt_in = 1'b0; sub_key_in_valid = 1'b1;
        round_key_ready_in = 1'b1;
        @(negedge clk_in);
        sub_key_in_valid = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("abort_at5", {3'd0, round_key_valid_out, round_idx_out, round_key_out},
            {3'd0, 1'b1, 4'd5, exp_keys[5]});
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("abort_idle", {61'd0, done_out, busy_out, round_key_valid_out}, 64'd0);
        k2 = rand56();
        build(k2, 1'b1);
        sub_key_in = k2; decrypt_in = 1'b1; sub_key_in_valid = 1'b1;
        @(negedge clk_in);
        sub_key_in_valid = 1'b0;
        chk("abort_restart", {2'd0, busy_out, round_key_valid_out, round_idx_out, round_key_out},
            {2'd0, 1'b1, 1'b1, 4'd0, exp_keys[0]});
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        round_key_ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_done", {62'd0, done_out, round_key_valid_out}, 64'd0);
            @(negedge clk_in);
        end

        // Asynchronous reset mid-schedule at idx 9.
        build(56'hFEDCBA9_8765432, 1'b0);
        sub_key_in = 56'hFEDCBA9_8765432; decrypt_in = 1'b0; sub_key_in_valid = 1'b1;
        round_key_ready_in = 1'b1;
        @(negedge clk_in);
        sub_key_in_valid = 1'b0;
        repeat (9) @(negedge clk_in);
        chk("rst_at9", {3'd0, round_key_valid_out, round_idx_out, round_key_out},
            {3'd0, 1'b1, 4'd9, exp_keys[9]});
        rst_n_in = 1'b0;
        #1;
        chk("rst_async",
            {round_key_out, round_idx_out, 1'b0, round_key_valid_out, busy_out, done_out, err_out}, 64'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        round_key_ready_in = 1'b0;
        @(negedge clk_in);
        chk("rst_no_done",
            {round_key_out, round_idx_out, 1'b0, round_key_valid_out, busy_out, done_out, err_out}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
